// File: rtl/muldiv_unit.sv
// Purpose : iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency : oDone 34 cycles after an accepted iStart; 2 cycles for divide-by-zero and signed overflow.
// Backpressure: iStart is ignored while oBusy; a new start is taken in IDLE or in the DONE cycle.
// Ports   : iCLK/iRST clock and async active-high reset; iStart/iFunct3/iA/iB request;
//           iFlush aborts the operation; oBusy/oDone status; oResult holds the last result.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [2:0]       iFunct3,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic               res_neg;
  logic [WIDTH-1:0]   opnd;    // multiplicand (mul) or divisor (div), magnitude
  logic [2*WIDTH-1:0] acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}

  // ---- operand preparation at accept time ----
  logic             is_div, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    is_div   = iFunct3[2];
    a_signed = (iFunct3 == 3'b001) || (iFunct3 == 3'b010) ||
               (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
    b_signed = (iFunct3 == 3'b001) || (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
    a_neg    = a_signed && iA[WIDTH-1];
    b_neg    = b_signed && iB[WIDTH-1];
    a_abs    = a_neg ? (~iA + 1'b1) : iA;
    b_abs    = b_neg ? (~iB + 1'b1) : iB;
    div_zero = is_div && (iB == '0);
    div_ovf  = is_div && !iFunct3[0] && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
  end

  // ---- one iteration of each algorithm ----
  logic [WIDTH:0]     mul_sum, trial, diff;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Restoring divide: shift next dividend bit into the remainder, subtract if it fits.
    trial    = acc[2*WIDTH-1:WIDTH-1];
    diff     = trial - {1'b0, opnd};
    ge       = (trial >= {1'b0, opnd});
    div_next = ge ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                  : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // ---- sign correction and output selection ----
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_word;

  always_comb begin
    prod = res_neg ? (~acc + 1'b1) : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    case (op)
      3'b000:                 fix_word = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_word = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_word = res_neg ? (~quo + 1'b1) : quo;
      default:                fix_word = res_neg ? (~rem + 1'b1) : rem;
    endcase
  end

  // ---- control ----
  // oBusy/oDone are registered from the state held before each edge, so they trail it by one cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      res_neg <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
    end else if (iFlush) begin
      state <= IDLE;
      cnt   <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oBusy <= (state == CALC) || (state == FIX);
      oDone <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            op  <= iFunct3;
            cnt <= '0;
            if (div_zero) begin
              // Preload the architectural answer and skip the iterations.
              res_neg <= 1'b0;
              acc     <= {iA, {WIDTH{1'b1}}};
              state   <= FIX;
            end else if (div_ovf) begin
              res_neg <= 1'b0;
              acc     <= {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
              state   <= FIX;
            end else begin
              // Remainder follows the dividend's sign; product and quotient follow a_neg ^ b_neg.
              res_neg <= (is_div && iFunct3[1]) ? a_neg : (a_neg ^ b_neg);
              opnd    <= is_div ? b_abs : a_abs;
              acc     <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
              state   <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          oResult <= fix_word;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port iCLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iStart  input  1  request pulse; operands and op sampled on the accepting edge.
REQ-005 SHALL have port iFunct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port iA  input  32  rs1 operand.
REQ-007 SHALL have port iB  input  32  rs2 operand.
REQ-008 SHALL have port iFlush  input  1  synchronous abort of the operation in flight.
REQ-009 SHALL have port oBusy  output  1  operation in progress; datapath stalls while high.
REQ-010 SHALL have port oDone  output  1  one-cycle pulse; oResult valid.
REQ-011 SHALL have port oResult  output  32  registered result, held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept iStart only in IDLE or DONE; iStart in CALC/FIX ignored, operands not resampled.
REQ-014 On accept SHALL latch the op, the absolute values of signed operands, and the result sign; transition to CALC with iteration counter = 0.
REQ-015 CALC SHALL run exactly 32 iterations, 1 per cycle: multiply = shift-add into a 64-bit accumulator; divide = restoring shift-subtract, 1 quotient bit per cycle.
REQ-016 After count 31 CALC SHALL go to FIX; FIX SHALL apply sign correction (two's-complement negate of 64-bit product, quotient or remainder as needed) and select the output word.
REQ-017 Output selection: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-018 Signedness: MULH both signed; MULHSU iA signed, iB unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed; remainder takes the sign of the dividend.
REQ-019 FIX SHALL go to DONE; DONE SHALL assert oDone for exactly one cycle, then go to IDLE unless a new start is accepted (then go to CALC).
REQ-020 Normal latency: start accepted at edge 0 -> oDone high after edge 34, low after edge 35.
REQ-021 Division by zero (iB = 0, DIV/DIVU/REM/REMU) SHALL bypass CALC (IDLE->FIX->DONE; oDone after edge 2): quotient 0xFFFFFFFF, remainder = iA.
REQ-022 Signed overflow (DIV/REM, iA = 0x80000000, iB = 0xFFFFFFFF) SHALL bypass CALC: quotient 0x80000000, remainder 0.
REQ-023 oBusy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-024 iFlush in any state SHALL force IDLE at the next edge with no oDone; oResult keeps its previous value; iFlush overrides a simultaneous iStart.
REQ-025 oResult SHALL change only on the edge entering DONE.

Reset
REQ-026 iRST high SHALL immediately force IDLE, oBusy = 0, oDone = 0, oResult = 0, counter = 0, regardless of iCLK.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no oDone SHALL follow reset release.
REQ-028 The first iStart SHALL be accepted on the first rising edge with iRST low.

Verification
REQ-029 MUL iA = 7, iB = -3 -> oDone after edge 34, oResult 0xFFFFFFEB; oBusy high edges 1-33 only.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-032 DIVU 5 / 0 -> oDone after edge 2, 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000 after edge 2.
REQ-033 Start, then iFlush at edge 10 -> IDLE, oBusy 0, no oDone, oResult unchanged; iRST pulse at edge 15 of a fresh operation -> all outputs 0 immediately, no oDone.
REQ-034 Back-to-back: iStart held during the DONE cycle -> second operation accepted, its oDone exactly 34 cycles after the first oDone; iStart pulses during CALC ignored.
